// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
// seg7_scan_driver: time-multiplexed 4-digit seven-segment driver with per-frame snapshot,
// anti-ghosting dead time and registered outputs. Define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_driver #(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYC    = 500,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Seg7,
  input  logic        Blank,
  output logic [7:0]  SegOut,
  output logic [3:0]  DigSel,
  output logic        FrameTick
);

  localparam int              CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYC);
  localparam logic [7:0]      SEG_OFF  = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0]      DIG_OFF  = DIG_ACT_LOW ? 4'hF : 4'h0;

  typedef enum logic {DEAD, SHOW} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             valid_q, valid_d;
  logic [7:0]       seg_out_q, seg_out_d;
  logic [3:0]       dig_sel_q, dig_sel_d;
  logic             frame_tick_q, frame_tick_d;

  logic             slot_wrap;
  logic             snap;
  logic             show;
  logic [7:0]       seg_raw;
  logic [3:0]       dig_raw;
  logic [3:0]       lzb_blank;

  // Slot timing and the frame snapshot; valid stays low until the first snapshot exists.
  always_comb begin
    slot_wrap    = (cnt_q == CNT_MAX);
    snap         = slot_wrap && (idx_q == 2'd3);
    cnt_d        = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d        = slot_wrap ? idx_q + 2'd1 : idx_q;
    shadow_d     = snap ? Seg7 : shadow_q;
    valid_d      = valid_q | snap;
    frame_tick_d = snap;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DEAD:    if (cnt_d == DEAD_LIM) state_d = SHOW;
      SHOW:    if (slot_wrap) state_d = (DEAD_CYC == 0) ? SHOW : DEAD;
      default: state_d = DEAD;
    endcase
  end

`ifdef SEG7_LZB_EN
  logic [3:0] is_zero;

  // A "0" digit is blanked only while every more-significant digit is also blank.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      is_zero[i] = (shadow_q[8*i +: 7] == 7'h3F);
    end
    lzb_blank[3] = is_zero[3];
    lzb_blank[2] = is_zero[3] & is_zero[2];
    lzb_blank[1] = is_zero[3] & is_zero[2] & is_zero[1];
    lzb_blank[0] = 1'b0;
  end
`else
  assign lzb_blank = 4'h0;
`endif

  always_comb begin
    show      = valid_q && (state_q == SHOW) && !Blank && !lzb_blank[idx_q];
    seg_raw   = show ? shadow_q[8*idx_q +: 8] : 8'h00;
    dig_raw   = show ? (4'b0001 << idx_q) : 4'h0;
    seg_out_d = SEG_ACT_LOW ? ~seg_raw : seg_raw;
    dig_sel_d = DIG_ACT_LOW ? ~dig_raw : dig_raw;
  end

  // Segments and digit selects share one register stage so they always switch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DEAD;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 32'h0;
      valid_q      <= 1'b0;
      seg_out_q    <= SEG_OFF;
      dig_sel_q    <= DIG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      valid_q      <= valid_d;
      seg_out_q    <= seg_out_d;
      dig_sel_q    <= dig_sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign SegOut    = seg_out_q;
  assign DigSel    = dig_sel_q;
  assign FrameTick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns/1ps
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver at SCAN_DIV=8, DEAD_CYC=2, active-low pins.
// Expected pin values are pushed as each cycle's inputs are driven and popped one cycle later.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV = 8;
  localparam int DEAD_CYC = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

`ifdef SEG7_LZB_EN
  localparam bit LZB_ON = 1'b1;
`else
  localparam bit LZB_ON = 1'b0;
`endif

  localparam logic [31:0] W1 = 32'h065B4F66;
  localparam logic [31:0] W2 = 32'h7F6D073F;
  localparam logic [31:0] Z1 = 32'h3F3F063F;
  localparam logic [31:0] Z2 = 32'h3F3F3F3F;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       tick;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] Seg7;
  logic        Blank;
  logic [7:0]  SegOut;
  logic [3:0]  DigSel;
  logic        FrameTick;

  exp_t        sb_q[$];
  exp_t        e;
  int          cyc;
  logic [31:0] snap_word;
  logic        snap_valid;
  int          checks;
  int          failures;

  seg7_scan_driver #(
    .SCAN_DIV   (SCAN_DIV),
    .DEAD_CYC   (DEAD_CYC),
    .SEG_ACT_LOW(1'b1),
    .DIG_ACT_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Seg7     (Seg7),
    .Blank    (Blank),
    .SegOut   (SegOut),
    .DigSel   (DigSel),
    .FrameTick(FrameTick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leading-zero rule: digit 0 never blanks; others blank when they and all higher digits read "0".
  function automatic logic lz_blanked(input logic [31:0] w, input int slot);
    logic all_zero;
    all_zero = 1'b1;
    for (int d = 3; d >= slot; d--) begin
      if (w[8*d +: 7] != 7'h3F) all_zero = 1'b0;
    end
    return LZB_ON && (slot != 0) && all_zero;
  endfunction

  // Drive this cycle's inputs, predict the pins for the next cycle, then move to the next negedge.
  task automatic step(input logic [31:0] seg7_v, input logic blank_v);
    exp_t       nx;
    int         cnt;
    int         slot;
    logic       show;
    logic [3:0] onehot;
    Seg7   = seg7_v;
    Blank  = blank_v;
    cnt    = cyc % SCAN_DIV;
    slot   = (cyc / SCAN_DIV) % 4;
    onehot = 4'b0001 << slot;
    show   = snap_valid && (cnt >= DEAD_CYC) && !blank_v && !lz_blanked(snap_word, slot);
    nx.seg  = show ? ~snap_word[8*slot +: 8] : 8'hFF;
    nx.dig  = show ? ~onehot : 4'hF;
    nx.tick = ((cyc + 1) % FRAME) == 0;
    sb_q.push_back(nx);
    if ((cyc % FRAME) == FRAME - 1) begin
      snap_word  = seg7_v;
      snap_valid = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic release_reset();
    sb_q.delete();
    cyc        = 0;
    snap_word  = 32'h0;
    snap_valid = 1'b0;
    sb_q.push_back('{seg: 8'hFF, dig: 4'hF, tick: 1'b0});
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    Seg7  = W1;
    Blank = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (SegOut !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL reset_segout got=%h expected=%h", SegOut, 8'hFF);
    end
    checks++;
    if (DigSel !== 4'hF) begin
      failures++;
      $display("[TB] FAIL reset_digsel got=%h expected=%h", DigSel, 4'hF);
    end
    checks++;
    if (FrameTick !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_tick got=%b expected=0", FrameTick);
    end
    release_reset();
  endtask

  task automatic test_first_frame();
    for (int i = 0; i < FRAME; i++) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL first_frame cyc=%0d got=no scoreboard entry", cyc);
      end else begin
        e = sb_q.pop_front(); checks++;
        if ({SegOut, DigSel, FrameTick} !== {e.seg, e.dig, e.tick}) begin
          failures++;
          $display("[TB] FAIL first_frame cyc=%0d got seg=%h dig=%h tick=%b expected seg=%h dig=%h tick=%b",
                   cyc, SegOut, DigSel, FrameTick, e.seg, e.dig, e.tick);
        end
      end
      step(W1, 1'b0);
    end
    checks++;
    if (FrameTick !== 1'b1 || DigSel !== 4'hF) begin
      failures++;
      $display("[TB] FAIL first_tick cyc=%0d got tick=%b dig=%h expected tick=1 dig=f", cyc, FrameTick, DigSel);
    end
  endtask

  task automatic test_steady_scan();
    for (int i = 0; i < FRAME; i++) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL steady_scan cyc=%0d got=no scoreboard entry", cyc);
      end else begin
        e = sb_q.pop_front(); checks++;
        if ({SegOut, DigSel, FrameTick} !== {e.seg, e.dig, e.tick}) begin
          failures++;
          $display("[TB] FAIL steady_scan cyc=%0d got seg=%h dig=%h tick=%b expected seg=%h dig=%h tick=%b",
                   cyc, SegOut, DigSel, FrameTick, e.seg, e.dig, e.tick);
        end
      end
      step(W1, 1'b0);
    end
  endtask

  task automatic test_tear_free();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL tear_free cyc=%0d got=no scoreboard entry", cyc);
      end else begin
        e = sb_q.pop_front(); checks++;
        if ({SegOut, DigSel, FrameTick} !== {e.seg, e.dig, e.tick}) begin
          failures++;
          $display("[TB] FAIL tear_free cyc=%0d got seg=%h dig=%h tick=%b expected seg=%h dig=%h tick=%b",
                   cyc, SegOut, DigSel, FrameTick, e.seg, e.dig, e.tick);
        end
      end
      step((i >= 2 * SCAN_DIV + 2) ? W2 : W1, 1'b0);
    end
  endtask

  task automatic test_blank_mid_slot();
    for (int i = 0; i < FRAME; i++) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL blank_mid_slot cyc=%0d got=no scoreboard entry", cyc);
      end else begin
        e = sb_q.pop_front(); checks++;
        if ({SegOut, DigSel, FrameTick} !== {e.seg, e.dig, e.tick}) begin
          failures++;
          $display("[TB] FAIL blank_mid_slot cyc=%0d got seg=%h dig=%h tick=%b expected seg=%h dig=%h tick=%b",
                   cyc, SegOut, DigSel, FrameTick, e.seg, e.dig, e.tick);
        end
      end
      step(W2, (i >= SCAN_DIV + 3) && (i <= SCAN_DIV + 5));
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != 5; i++) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL async_reset_pre cyc=%0d got=no scoreboard entry", cyc);
      end else begin
        e = sb_q.pop_front(); checks++;
        if ({SegOut, DigSel, FrameTick} !== {e.seg, e.dig, e.tick}) begin
          failures++;
          $display("[TB] FAIL async_reset_pre cyc=%0d got seg=%h dig=%h tick=%b expected seg=%h dig=%h tick=%b",
                   cyc, SegOut, DigSel, FrameTick, e.seg, e.dig, e.tick);
        end
      end
      step(W2, 1'b0);
    end
    checks++;
    if (DigSel !== 4'hE || SegOut !== 8'hC0) begin
      failures++;
      $display("[TB] FAIL async_reset_lit got seg=%h dig=%h expected seg=c0 dig=e", SegOut, DigSel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (SegOut !== 8'hFF || DigSel !== 4'hF || FrameTick !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset_off got seg=%h dig=%h tick=%b expected seg=ff dig=f tick=0",
               SegOut, DigSel, FrameTick);
    end
    repeat (2) @(negedge clk);
    release_reset();
    for (int i = 0; i < FRAME + SCAN_DIV; i++) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL async_restart cyc=%0d got=no scoreboard entry", cyc);
      end else begin
        e = sb_q.pop_front(); checks++;
        if ({SegOut, DigSel, FrameTick} !== {e.seg, e.dig, e.tick}) begin
          failures++;
          $display("[TB] FAIL async_restart cyc=%0d got seg=%h dig=%h tick=%b expected seg=%h dig=%h tick=%b",
                   cyc, SegOut, DigSel, FrameTick, e.seg, e.dig, e.tick);
        end
      end
      step(W2, 1'b0);
    end
  endtask

  task automatic test_leading_zero();
    for (int i = 0; i < 4 * FRAME && cyc < 4 * FRAME + 2; i++) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL leading_zero cyc=%0d got=no scoreboard entry", cyc);
      end else begin
        e = sb_q.pop_front(); checks++;
        if ({SegOut, DigSel, FrameTick} !== {e.seg, e.dig, e.tick}) begin
          failures++;
          $display("[TB] FAIL leading_zero cyc=%0d got seg=%h dig=%h tick=%b expected seg=%h dig=%h tick=%b",
                   cyc, SegOut, DigSel, FrameTick, e.seg, e.dig, e.tick);
        end
      end
      step((cyc < 2 * FRAME) ? Z1 : Z2, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL back_to_back cyc=%0d got=no scoreboard entry", cyc);
      end else begin
        e = sb_q.pop_front(); checks++;
        if ({SegOut, DigSel, FrameTick} !== {e.seg, e.dig, e.tick}) begin
          failures++;
          $display("[TB] FAIL back_to_back cyc=%0d got seg=%h dig=%h tick=%b expected seg=%h dig=%h tick=%b",
                   cyc, SegOut, DigSel, FrameTick, e.seg, e.dig, e.tick);
        end
      end
      step($urandom, ($urandom_range(7) == 0));
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    snap_word  = 32'h0;
    snap_valid = 1'b0;
    rst_n      = 1'b0;
    Seg7       = 32'h0;
    Blank      = 1'b0;
    test_reset();
    test_first_frame();
    test_steady_scan();
    test_tear_free();
    test_blank_mid_slot();
    test_async_reset();
    test_leading_zero();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
